// File: rtl/or_nb_sync.sv
// Registered N-input OR event aggregator.
// Each input can be inverted and individually masked. The design supports a
// retriggerable minimum-pulse stretch (level mode) or sticky capture with
// clear (sticky mode). O and SRC are driven directly by flops.

module or_nb_sync #(
    parameter int unsigned          WIDTH    = 4,
    parameter logic [WIDTH-1:0]     INV_MASK = WIDTH'(1),
    parameter bit                   STICKY   = 1'b0,
    parameter int unsigned          STRETCH  = 0
) (
    input  logic             C,
    input  logic             R_N,
    input  logic             CE,
    input  logic [WIDTH-1:0] I,
    input  logic [WIDTH-1:0] EN,
    input  logic             CLR,
    output logic             O,
    output logic [WIDTH-1:0] SRC
);

    // Counter is at least one bit wide so that STRETCH=0 still elaborates.
    localparam int unsigned CNT_W = (STRETCH == 0) ? 1 : $clog2(STRETCH + 1);
    localparam logic [CNT_W-1:0] STRETCH_V = CNT_W'(STRETCH);

    // Reject illegal parameter values when the design is elaborated.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("or_nb_sync: WIDTH must be in 1..32");
    end
    if (STRETCH > 255) begin : g_bad_stretch
        $error("or_nb_sync: STRETCH must be in 0..255");
    end

    logic [WIDTH-1:0] x;
    logic             hit;
    logic [WIDTH-1:0] src_q, src_d;
    logic             o_q, o_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Effective inputs: polarity-corrected, then masked.
    always_comb begin
        x   = (I ^ INV_MASK) & EN;
        hit = |x;
    end

    // Next-state logic for the flag, source mask and stretch counter.
    always_comb begin
        src_d = src_q;
        o_d   = o_q;
        cnt_d = cnt_q;
        if (STICKY) begin
            if (CE) begin
                // Clear first, then OR in new hits so a same-cycle hit survives.
                src_d = (CLR ? '0 : src_q) | x;
                o_d   = |src_d;
            end else if (CLR) begin
                // Clear works even while the clock enable is low; inputs are not sampled.
                src_d = '0;
                o_d   = 1'b0;
            end
        end else if (CE) begin
            src_d = x;
            if (hit) begin
                cnt_d = STRETCH_V;
                o_d   = 1'b1;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
                o_d   = 1'b1;
            end else begin
                o_d   = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge C) begin
        if (!R_N) begin
            src_q <= '0;
            o_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            src_q <= src_d;
            o_q   <= o_d;
            cnt_q <= cnt_d;
        end
    end

    assign O   = o_q;
    assign SRC = src_q;

endmodule

// File: tb/tb_or_nb_sync.sv
// Bench for or_nb_sync. It runs three instances: the default parameters, a
// stretch of 3, and sticky mode. Expected results are queued before each edge
// and compared after it.

module tb_or_nb_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce0, ce1, ce2;
    logic       clr0, clr1, clr2;
    logic [3:0] i0, i1, i2;
    logic [3:0] en0, en1, en2;
    logic       o0, o1, o2;
    logic [3:0] src0, src1, src2;

    always #5 clk = ~clk;

    or_nb_sync u_def (
        .C(clk), .R_N(rst_n), .CE(ce0), .I(i0), .EN(en0), .CLR(clr0), .O(o0), .SRC(src0)
    );

    or_nb_sync #(.WIDTH(4), .INV_MASK(4'b0000), .STICKY(1'b0), .STRETCH(3)) u_str (
        .C(clk), .R_N(rst_n), .CE(ce1), .I(i1), .EN(en1), .CLR(clr1), .O(o1), .SRC(src1)
    );

    or_nb_sync #(.WIDTH(4), .INV_MASK(4'b0000), .STICKY(1'b1), .STRETCH(0)) u_stk (
        .C(clk), .R_N(rst_n), .CE(ce2), .I(i2), .EN(en2), .CLR(clr2), .O(o2), .SRC(src2)
    );

    typedef struct {
        string       tag;
        int unsigned dut;
        logic [4:0]  exp;   // {O, SRC}
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [4:0] observe(input int unsigned dut);
        case (dut)
            0:       return {o0, src0};
            1:       return {o1, src1};
            default: return {o2, src2};
        endcase
    endfunction

    task automatic push(input string tag, input int unsigned dut, input logic o,
                        input logic [3:0] src);
        exp_t e;
        e.tag = tag;
        e.dut = dut;
        e.exp = {o, src};
        sbq.push_back(e);
    endtask

    // Advance one clock, then drain the scoreboard against the registered outputs.
    task automatic cycle();
        exp_t       e;
        logic [4:0] obs;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.dut);
            n_cmp++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed O/SRC=%b/%b expected %b/%b",
                       e.tag, obs[4], obs[3:0], e.exp[4], e.exp[3:0]);
            end
        end
    endtask

    logic [3:0] str_in [7] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic       str_o  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        {ce0, ce1, ce2}    = 3'b111;
        {clr0, clr1, clr2} = 3'b000;
        i0 = 4'b0000; i1 = 4'b0000; i2 = 4'b1111;
        en0 = 4'b1111; en1 = 4'b1111; en2 = 4'b1111;

        // Reset state
        push("rst_def", 0, 1'b0, 4'b0000);
        push("rst_str", 1, 1'b0, 4'b0000);
        push("rst_stk", 2, 1'b0, 4'b0000);
        cycle();
        rst_n = 1'b1;
        i2 = 4'b0000;
        cycle();

        // Default: input 0 is active-low
        i0 = 4'b0001; push("def_i0001", 0, 1'b0, 4'b0000); cycle();
        i0 = 4'b0000; push("def_i0000", 0, 1'b1, 4'b0001); cycle();
        i0 = 4'b1001; push("def_i1001", 0, 1'b1, 4'b1000); cycle();
        en0 = 4'b1110; i0 = 4'b0000; push("def_mask", 0, 1'b0, 4'b0000); cycle();
        en0 = 4'b1111; push("def_unmask", 0, 1'b1, 4'b0001); cycle();
        // Non-sticky CE=0 holds and ignores CLR
        ce0 = 1'b0; clr0 = 1'b1; i0 = 4'b1001;
        push("def_ce0_hold", 0, 1'b1, 4'b0001); cycle();
        clr0 = 1'b0;

        // Stretch: one-cycle pulse gives 4 high cycles
        i1 = 4'b0100; push("str_p0", 1, 1'b1, 4'b0100); cycle();
        i1 = 4'b0000;
        push("str_p1", 1, 1'b1, 4'b0000); cycle();
        push("str_p2", 1, 1'b1, 4'b0000); cycle();
        push("str_p3", 1, 1'b1, 4'b0000); cycle();
        push("str_end", 1, 1'b0, 4'b0000); cycle();
        // Retrigger two cycles after the first pulse: 6 high cycles
        for (int k = 0; k < 7; k++) begin
            i1 = str_in[k];
            push($sformatf("str_retrig%0d", k), 1, str_o[k], str_in[k]);
            cycle();
        end

        // Sticky capture
        i2 = 4'b0010; push("stk_cap1", 2, 1'b1, 4'b0010); cycle();
        i2 = 4'b1000; push("stk_cap3", 2, 1'b1, 4'b1010); cycle();
        i2 = 4'b0000; push("stk_hold", 2, 1'b1, 4'b1010); cycle();
        clr2 = 1'b1; push("stk_clr", 2, 1'b0, 4'b0000); cycle();
        i2 = 4'b0100; push("stk_clr_hit", 2, 1'b1, 4'b0100); cycle();
        clr2 = 1'b0; i2 = 4'b0000; push("stk_clr_hit_hold", 2, 1'b1, 4'b0100); cycle();
        clr2 = 1'b1; i2 = 4'b0011; push("stk_load0011", 2, 1'b1, 4'b0011); cycle();
        clr2 = 1'b0; i2 = 4'b0000;
        // CE/CLR interaction
        ce2 = 1'b0; i2 = 4'b1100; push("stk_ce0_hold", 2, 1'b1, 4'b0011); cycle();
        clr2 = 1'b1; push("stk_ce0_clr", 2, 1'b0, 4'b0000); cycle();
        clr2 = 1'b0; ce2 = 1'b1; i2 = 4'b0000; push("stk_after_clr", 2, 1'b0, 4'b0000); cycle();

        // Reset during an active stretch and a sticky capture
        i1 = 4'b0100; i2 = 4'b0001;
        push("pre_rst_str", 1, 1'b1, 4'b0100);
        push("pre_rst_stk", 2, 1'b1, 4'b0001);
        cycle();
        rst_n = 1'b0; i1 = 4'b0000; i2 = 4'b0000; i0 = 4'b0000;
        push("mid_rst_def", 0, 1'b0, 4'b0000);
        push("mid_rst_str", 1, 1'b0, 4'b0000);
        push("mid_rst_stk", 2, 1'b0, 4'b0000);
        cycle();
        rst_n = 1'b1;
        push("post_rst_str0", 1, 1'b0, 4'b0000);
        push("post_rst_stk0", 2, 1'b0, 4'b0000);
        cycle();
        push("post_rst_str1", 1, 1'b0, 4'b0000);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
